entrada_fpga_hs: RTL
====================

Name: entrada_fpga_hs

Overview:
Handshaked user-input port for the processor: the inbound counterpart of the display output path. When the control unit raises its IN signal, the block freezes the PC and waits for the user to press a confirm button. It then latches the slide switches and presents the value for one cycle to the immediate/switch mux feeding extensor_sinal1. It runs on the processor clock and contains a synchronizer and a debouncer for the push button.

Parameters:
SW_WIDTH, 8, number of slide switches sampled
DATA_WIDTH, 14, width of value delivered to the immediate path (zero-extended from SW_WIDTH)
DEB_CYCLES, 16, consecutive processor-clock cycles a button level must hold to be accepted (>=2)

Ports:
clock  in  1  processor clock; all state on rising edge
reset  in  1  asynchronous, active-low; state is cleared while low
sinal_in  in  1  IN request from unidade_controle; held for the duration of the IN instruction
switches  in  SW_WIDTH  raw slide switches, asynchronous
botao  in  1  raw confirm push button, active-high, asynchronous, bouncy
dado_in  out  DATA_WIDTH  captured switch value, registered, zero-extended
in_pronto  out  1  one-cycle strobe: dado_in is valid and the IN instruction completes
congela_pc  out  1  stall to PC (combined with halt); high while waiting for the user
aguardando  out  1  LED indicator, registered copy of "waiting for press"

Behaviour:
- Reset (reset=0): state OCIOSO; dado_in=0; in_pronto=0; aguardando=0; sync flops=0; debounce counter=0; btn_estavel=0; btn_prev=0. congela_pc=0 while reset is low.
- Synchronizers: botao and switches each pass through 2 flops (btn_sync, sw_sync).
- Debounce: if btn_sync != btn_estavel, the counter increments. When the counter reaches DEB_CYCLES-1 and the values still differ, btn_estavel <= btn_sync and the counter returns to 0. If btn_sync == btn_estavel, the counter returns to 0. btn_prev <= btn_estavel every cycle. aperto = btn_estavel & ~btn_prev (combinational).
- FSM states: OCIOSO, ESPERA_SOLTO, ESPERA_APERTO, CAPTURA.
- OCIOSO: if sinal_in=1, go to ESPERA_SOLTO.
- ESPERA_SOLTO: if sinal_in=0, go to OCIOSO. Else if btn_estavel=0, go to ESPERA_APERTO. A button already held down is never accepted as a press.
- ESPERA_APERTO: if sinal_in=0, go to OCIOSO (abort, no capture). Else if aperto=1, dado_in <= {zeros, sw_sync} and go to CAPTURA.
- CAPTURA: always go to OCIOSO.
- congela_pc (combinational) = (state==OCIOSO & sinal_in) | state==ESPERA_SOLTO | state==ESPERA_APERTO. The PC is held in the same cycle the IN opcode appears.
- in_pronto = (state==CAPTURA). congela_pc=0 in that cycle, so the PC advances at the end of it.
- aguardando <= next_state is ESPERA_SOLTO or ESPERA_APERTO.
- dado_in holds its value until the next capture or reset; it is not cleared on abort.
- Back-to-back IN: after CAPTURA, OCIOSO sees sinal_in=1 and re-arms through ESPERA_SOLTO. Each instruction needs a release and a new press.
- Timing: with botao raw rising at edge 0 and staying stable, btn_sync=1 after edge 2, btn_estavel=1 after edge 2+DEB_CYCLES, and CAPTURA is entered at edge 3+DEB_CYCLES.
- The switches value captured is sw_sync at the capture edge. Switch changes within 2 cycles before the press may be missed; this is accepted.
- Asynchronous reset mid-wait returns the block to OCIOSO immediately. congela_pc drops, and the next IN restarts from OCIOSO.

Decomposition:
- Shared package entrada_pkg holds the FSM state encoding (2-bit: OCIOSO=0, ESPERA_SOLTO=1, ESPERA_APERTO=2, CAPTURA=3) and the default DEB_CYCLES.
- One sub-module, debouncer_botao. It contains the 2-flop synchronizer, the counter sized $clog2(DEB_CYCLES), btn_estavel, and the aperto edge output.
- Switch synchronizers and the FSM stay in the top module.

Test Plan:
(Benches use DEB_CYCLES=4 unless stated.)
1. Reset then idle: reset=0 for 3 cycles, then 1; sinal_in=0, botao toggling -> dado_in=0, in_pronto=0, congela_pc=0 throughout.
2. Basic capture: switches=8'hA5; sinal_in=1 from cycle 10; botao=1 from cycle 20 -> congela_pc=1 from cycle 10; in_pronto=1 exactly at the edge 3+4=7 cycles after the botao rise; dado_in=14'h00A5; congela_pc=0 in that cycle.
3. Bounce rejection: botao toggles every 2 cycles for 20 cycles, then held high -> exactly one in_pronto, only after 4 stable cycles.
4. Held button: botao already held high when sinal_in rises -> state stays ESPERA_SOLTO and no in_pronto until release (4 stable low cycles) and a new press; then dado_in equals the switches at that press.
5. Back-to-back IN: sinal_in held high across two instructions, switches 8'h03 then 8'hFF with a release between presses -> two in_pronto pulses, dado_in 14'h0003 then 14'h00FF.
6. Abort and reset: sinal_in drops during ESPERA_APERTO -> OCIOSO, congela_pc=0, dado_in unchanged. Asserting reset=0 mid-wait -> congela_pc=0 and aguardando=0 immediately.

Source files
------------

// File: rtl/entrada_fpga_hs_pkg.sv
// Shared constants for the user-input port: FSM encoding and default debounce length.
package entrada_pkg;

  localparam int DEB_CYCLES_DEF = 16;

  localparam logic [1:0] OCIOSO        = 2'd0;
  localparam logic [1:0] ESPERA_SOLTO  = 2'd1;
  localparam logic [1:0] ESPERA_APERTO = 2'd2;
  localparam logic [1:0] CAPTURA       = 2'd3;

  // True in the two states where the user is expected to act.
  function automatic logic is_espera(input logic [1:0] st);
    return (st == ESPERA_SOLTO) || (st == ESPERA_APERTO);
  endfunction

endpackage

// File: rtl/entrada_fpga_hs_if.sv
// Bundle of the user-input port signals: request from control, raw user
// inputs, and the value/strobe/stall going back into the datapath.
interface entrada_fpga_hs_if #(
  parameter int SW_WIDTH   = 8,
  parameter int DATA_WIDTH = 14
);
  logic                  sinal_in;
  logic [SW_WIDTH-1:0]   switches;
  logic                  botao;
  logic [DATA_WIDTH-1:0] dado_in;
  logic                  in_pronto;
  logic                  congela_pc;
  logic                  aguardando;

  modport master (
    output sinal_in, switches, botao,
    input  dado_in, in_pronto, congela_pc, aguardando
  );

  modport slave (
    input  sinal_in, switches, botao,
    output dado_in, in_pronto, congela_pc, aguardando
  );
endinterface

// File: rtl/debouncer_botao.sv
// Push-button conditioner: 2-flop synchronizer, run-length debouncer and
// rising-edge detector on the accepted (stable) level.
module debouncer_botao
  import entrada_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic botao,
  output logic btn_estavel,
  output logic aperto
);

  localparam int              CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [1:0]    btn_ff;   // [0] metastability stage, [1] synchronized
  logic          btn_sync;
  logic [CW-1:0] cnt;
  logic          btn_prev;

  assign btn_sync = btn_ff[1];

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) btn_ff <= '0;
    else        btn_ff <= {btn_ff[0], botao};
  end

  // Accept a new level only after it has differed for DEB_CYCLES straight edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      btn_estavel <= 1'b0;
    end else if (btn_sync == btn_estavel) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      btn_estavel <= btn_sync;
      cnt         <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed stable level for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) btn_prev <= 1'b0;
    else        btn_prev <= btn_estavel;
  end

  assign aperto = btn_estavel & ~btn_prev;

endmodule

// File: rtl/entrada_fpga_hs.sv
// IN-instruction user port: stalls the PC while an IN is pending, waits for a
// release followed by a fresh debounced press, then latches the switches and
// strobes in_pronto for one cycle.
module entrada_fpga_hs
  import entrada_pkg::*;
#(
  parameter int SW_WIDTH   = 8,
  parameter int DATA_WIDTH = 14,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic                clock,
  input  logic                reset,
  entrada_fpga_hs_if.slave    bus
);

  logic [1:0]                 state, state_nxt;
  logic                       captura;
  logic                       btn_estavel, aperto;
  logic [1:0][SW_WIDTH-1:0]   sw_ff;    // [0] metastability stage, [1] synchronized
  logic [SW_WIDTH-1:0]        sw_sync;
  logic [DATA_WIDTH-1:0]      dado_q;
  logic                       aguardando_q;

  assign sw_sync = sw_ff[1];

  debouncer_botao #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clock       (clock),
    .reset       (reset),
    .botao       (bus.botao),
    .btn_estavel (btn_estavel),
    .aperto      (aperto)
  );

  // Two-flop synchronizer for the slide switches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sw_ff <= '0;
    else        sw_ff <= {sw_ff[0], bus.switches};
  end

  // Next-state logic; a button held when the IN arrives must be released first.
  always_comb begin
    state_nxt = state;
    captura   = 1'b0;
    case (state)
      OCIOSO:        if (bus.sinal_in) state_nxt = ESPERA_SOLTO;
      ESPERA_SOLTO:  if (!bus.sinal_in)  state_nxt = OCIOSO;
                     else if (!btn_estavel) state_nxt = ESPERA_APERTO;
      ESPERA_APERTO: if (!bus.sinal_in) state_nxt = OCIOSO;
                     else if (aperto) begin
                       state_nxt = CAPTURA;
                       captura   = 1'b1;
                     end
      CAPTURA:       state_nxt = OCIOSO;
      default:       state_nxt = OCIOSO;
    endcase
  end

  // State register, captured value (kept across aborts) and waiting LED.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= OCIOSO;
      dado_q       <= '0;
      aguardando_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      aguardando_q <= is_espera(state_nxt);
      if (captura) dado_q <= DATA_WIDTH'(sw_sync);
    end
  end

  // Stall starts in the same cycle the IN opcode appears; never while in reset.
  assign bus.congela_pc = reset & (((state == OCIOSO) & bus.sinal_in) | is_espera(state));
  assign bus.in_pronto  = (state == CAPTURA);
  assign bus.dado_in    = dado_q;
  assign bus.aguardando = aguardando_q;

endmodule
